// File: rtl/ex_mem_skid_reg_if.sv
// ex_mem_skid_reg_if: valid/ready pipeline bus carrying one EX->MEM entry.
interface ex_mem_skid_reg_if #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int SIZE_W  = 3
);
  logic               valid;
  logic               ready;
  logic               regwrite;
  logic               memtoreg;
  logic               memread;
  logic               memwrite;
  logic [SIZE_W-1:0]  size;
  logic [DATA_W-1:0]  aluresult;
  logic [DATA_W-1:0]  rs2data;
  logic [RADDR_W-1:0] rd;
  modport master (output valid, regwrite, memtoreg, memread, memwrite, size, aluresult, rs2data, rd,
                  input ready);
  modport slave  (input valid, regwrite, memtoreg, memread, memwrite, size, aluresult, rs2data, rd,
                  output ready);
endinterface

// File: rtl/ex_mem_skid_reg.sv
// ex_mem_skid_reg: EX->MEM pipeline register with 2-entry skid buffer, flush and forwarding taps.
module ex_mem_skid_reg #(
  parameter int DATA_W     = 32,
  parameter int RADDR_W    = 5,
  parameter int SIZE_W     = 3,
  parameter int RD0_SQUASH = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  ex_mem_skid_reg_if.slave   exBus,
  ex_mem_skid_reg_if.master  memBus,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_rd_o,
  output logic [DATA_W-1:0]  fwd_data_o
);
  typedef struct packed {
    logic               regwrite;
    logic               memtoreg;
    logic               memread;
    logic               memwrite;
    logic [SIZE_W-1:0]  size;
    logic [DATA_W-1:0]  aluresult;
    logic [DATA_W-1:0]  rs2data;
    logic [RADDR_W-1:0] rd;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state;
  entry_t outQ, skidQ, inEntry;
  logic   validQ, readyQ, acc, drn;
  function automatic entry_t dropCtrl(input entry_t e);
    dropCtrl          = e;
    dropCtrl.regwrite = 1'b0;
    dropCtrl.memtoreg = 1'b0;
    dropCtrl.memread  = 1'b0;
    dropCtrl.memwrite = 1'b0;
  endfunction
  always_comb begin
    inEntry.regwrite  = exBus.regwrite & ~((RD0_SQUASH != 0) & (exBus.rd == '0));
    inEntry.memtoreg  = exBus.memtoreg;
    inEntry.memread   = exBus.memread;
    inEntry.memwrite  = exBus.memwrite;
    inEntry.size      = exBus.size;
    inEntry.aluresult = exBus.aluresult;
    inEntry.rs2data   = exBus.rs2data;
    inEntry.rd        = exBus.rd;
  end
  assign acc = exBus.valid & readyQ & ~flush_i;
  assign drn = validQ & memBus.ready;
  // Control bits are cleared whenever OUT empties, so valid_o=0 always reads as a bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= EMPTY;
      validQ <= 1'b0;
      readyQ <= 1'b1;
      outQ   <= '0;
      skidQ  <= '0;
    end else if (flush_i) begin
      state  <= EMPTY;
      validQ <= 1'b0;
      readyQ <= 1'b1;
      outQ   <= dropCtrl(outQ);
    end else begin
      unique case (state)
        EMPTY: if (acc) begin
          state  <= ONE;
          validQ <= 1'b1;
          outQ   <= inEntry;
        end
        ONE: if (acc && drn) begin
          outQ <= inEntry;
        end else if (acc) begin
          state  <= FULL;
          readyQ <= 1'b0;
          skidQ  <= inEntry;
        end else if (drn) begin
          state  <= EMPTY;
          validQ <= 1'b0;
          outQ   <= dropCtrl(outQ);
        end
        FULL: if (drn) begin
          state  <= ONE;
          readyQ <= 1'b1;
          outQ   <= skidQ;
        end
        default: begin
          state  <= EMPTY;
          validQ <= 1'b0;
          readyQ <= 1'b1;
        end
      endcase
    end
  end
  assign exBus.ready      = readyQ;
  assign memBus.valid     = validQ;
  assign memBus.regwrite  = outQ.regwrite;
  assign memBus.memtoreg  = outQ.memtoreg;
  assign memBus.memread   = outQ.memread;
  assign memBus.memwrite  = outQ.memwrite;
  assign memBus.size      = outQ.size;
  assign memBus.aluresult = outQ.aluresult;
  assign memBus.rs2data   = outQ.rs2data;
  assign memBus.rd        = outQ.rd;
  assign fwd_valid_o      = validQ & outQ.regwrite;
  assign fwd_rd_o         = outQ.rd;
  assign fwd_data_o       = outQ.aluresult;
endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// tb_ex_mem_skid_reg: random + directed stimulus against a queue model; two DUTs cover both RD0_SQUASH settings.
module tb_ex_mem_skid_reg;
  typedef struct packed {
    logic        regwrite;
    logic        memtoreg;
    logic        memread;
    logic        memwrite;
    logic [2:0]  size;
    logic [31:0] alu;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } ent_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  int   nChecks = 0, nErrors = 0;
  ent_t q[$];
  logic        fwdValidA, fwdValidB;
  logic [4:0]  fwdRdA, fwdRdB;
  logic [31:0] fwdDataA, fwdDataB;
  ex_mem_skid_reg_if exA(), memA(), exB(), memB();
  assign exB.valid     = exA.valid;
  assign exB.regwrite  = exA.regwrite;
  assign exB.memtoreg  = exA.memtoreg;
  assign exB.memread   = exA.memread;
  assign exB.memwrite  = exA.memwrite;
  assign exB.size      = exA.size;
  assign exB.aluresult = exA.aluresult;
  assign exB.rs2data   = exA.rs2data;
  assign exB.rd        = exA.rd;
  assign memB.ready    = memA.ready;
  ex_mem_skid_reg #(.RD0_SQUASH(1)) dutA (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .exBus(exA), .memBus(memA),
    .fwd_valid_o(fwdValidA), .fwd_rd_o(fwdRdA), .fwd_data_o(fwdDataA));
  ex_mem_skid_reg #(.RD0_SQUASH(0)) dutB (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .exBus(exB), .memBus(memB),
    .fwd_valid_o(fwdValidB), .fwd_rd_o(fwdRdB), .fwd_data_o(fwdDataB));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic ent_t mkEnt(input logic [31:0] alu);
    mkEnt = '0;
    mkEnt.alu = alu;
    mkEnt.regwrite = 1'b1;
    mkEnt.rd = 5'd7;
  endfunction
  function automatic ent_t randEnt();
    randEnt.regwrite = 1'($urandom);
    randEnt.memtoreg = 1'($urandom);
    randEnt.memread  = 1'($urandom);
    randEnt.memwrite = 1'($urandom);
    randEnt.size     = 3'($urandom);
    randEnt.alu      = $urandom;
    randEnt.rs2      = $urandom;
    randEnt.rd       = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction
  task automatic checkOutputs();
    logic hv;
    ent_t h;
    hv = q.size() > 0;
    h  = hv ? q[0] : '0;
    check("validA", memA.valid, hv);
    check("validB", memB.valid, hv);
    check("readyA", exA.ready, q.size() < 2);
    check("readyB", exB.ready, q.size() < 2);
    check("regwriteA", memA.regwrite, hv && h.regwrite && h.rd != 0);
    check("regwriteB", memB.regwrite, hv && h.regwrite);
    check("memreadA", memA.memread, hv && h.memread);
    check("memwriteA", memA.memwrite, hv && h.memwrite);
    check("fwdValidA", fwdValidA, hv && h.regwrite && h.rd != 0);
    check("fwdValidB", fwdValidB, hv && h.regwrite);
    if (hv) begin
      check("memtoregA", memA.memtoreg, h.memtoreg);
      check("sizeA", memA.size, h.size);
      check("aluA", memA.aluresult, h.alu);
      check("rs2A", memA.rs2data, h.rs2);
      check("rdA", memA.rd, h.rd);
      check("fwdRdA", fwdRdA, h.rd);
      check("fwdDataA", fwdDataA, h.alu);
      check("aluB", memB.aluresult, h.alu);
      check("rdB", fwdRdB, h.rd);
      check("fwdDataB", fwdDataB, h.alu);
    end
  endtask
  // Drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic rdy, input logic fl, input ent_t e);
    logic acc, drn;
    exA.valid = v;
    exA.regwrite = e.regwrite;
    exA.memtoreg = e.memtoreg;
    exA.memread = e.memread;
    exA.memwrite = e.memwrite;
    exA.size = e.size;
    exA.aluresult = e.alu;
    exA.rs2data = e.rs2;
    exA.rd = e.rd;
    memA.ready = rdy;
    flush = fl;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      drn = q.size() > 0 && rdy;
      acc = v && q.size() < 2;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    checkOutputs();
  endtask
  initial begin
    ent_t st;
    step(1'b0, 1'b0, 1'b0, '0);
    check("rstAlu", memA.aluresult, 0);
    check("rstRd", memA.rd, 0);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, mkEnt(32'h10 + i));
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b1, 1'b0, 1'b0, mkEnt(32'hA));
    step(1'b1, 1'b0, 1'b0, mkEnt(32'hB));
    check("skidFullReady", exA.ready, 1'b0);
    step(1'b1, 1'b0, 1'b0, mkEnt(32'hC));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, mkEnt(32'hC + i));
    step(1'b1, 1'b0, 1'b0, mkEnt(32'h20));
    step(1'b1, 1'b0, 1'b0, mkEnt(32'h21));
    step(1'b1, 1'b0, 1'b1, mkEnt(32'h22));
    check("flushReady", exA.ready, 1'b1);
    step(1'b1, 1'b1, 1'b0, mkEnt(32'h23));
    st = mkEnt(32'h30);
    st.rd = 5'd0;
    step(1'b1, 1'b1, 1'b0, st);
    check("rd0Squash", memA.regwrite, 1'b0);
    check("rd0Keep", memB.regwrite, 1'b1);
    st = '0;
    st.memwrite = 1'b1;
    st.rs2 = 32'hDEADBEEF;
    st.size = 3'b010;
    st.alu = 32'h100;
    step(1'b1, 1'b0, 1'b0, st);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, '0);
    check("storeDone", memA.memwrite, 1'b0);
    step(1'b1, 1'b0, 1'b0, mkEnt(32'h40));
    step(1'b1, 1'b0, 1'b0, mkEnt(32'h41));
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("asyncValid", memA.valid, 1'b0);
    check("asyncReady", exA.ready, 1'b1);
    check("asyncAlu", memA.aluresult, 0);
    check("asyncRd", memA.rd, 0);
    check("asyncRw", memA.regwrite, 0);
    check("asyncFwd", fwdValidA, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutputs();
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), randEnt());
    $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
    $finish;
  end
endmodule
